// File: rtl/pss_search_ctrl_if.sv
// Correlator-to-sequencer bus: per-sample magnitudes in, peak reports out.
interface pss_search_ctrl_if #(
    parameter int unsigned OUT_DW  = 24,
    parameter int unsigned TIME_DW = 32
) ();
    logic [3*OUT_DW-1:0] corr_i;
    logic                corr_valid_i;
    logic                peak_valid_o;
    logic [1:0]          peak_n_id_2_o;
    logic [TIME_DW-1:0]  peak_time_o;
    logic [OUT_DW-1:0]   peak_mag_o;

    // Correlator/frame-sync side: supplies magnitudes, consumes peak reports
    modport master (
        output corr_i, corr_valid_i,
        input  peak_valid_o, peak_n_id_2_o, peak_time_o, peak_mag_o
    );

    // Sequencer side
    modport slave (
        input  corr_i, corr_valid_i,
        output peak_valid_o, peak_n_id_2_o, peak_time_o, peak_mag_o
    );
endinterface

// File: rtl/pss_search_ctrl.sv
// PSS search/track sequencer for the three N_ID_2 correlators.
module pss_search_ctrl #(
    parameter int unsigned OUT_DW    = 24,
    parameter int unsigned PERIOD    = 19200,
    parameter int unsigned HOLD_LEN  = 8,
    parameter int unsigned TRACK_WIN = 4,
    parameter int unsigned MAX_MISS  = 3,
    parameter int unsigned TIME_DW   = 32
) (
    input  logic                              clk_i,
    input  logic                              reset_ni,
    input  logic                              enable_i,
    input  logic [OUT_DW-1:0]                 threshold_i,
    pss_search_ctrl_if.slave                  bus,
    output logic [2:0]                        corr_enable_o,
    output logic                              locked_o,
    output logic [$clog2(MAX_MISS+1)-1:0]     miss_cnt_o,
    output logic [1:0]                        state_o
);
    localparam int unsigned MW = $clog2(MAX_MISS + 1);
    localparam int unsigned HW = (HOLD_LEN < 2) ? 1 : $clog2(HOLD_LEN + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        HOLD   = 2'd2,
        TRACK  = 2'd3
    } state_t;

    state_t              r_state;
    logic [TIME_DW-1:0]  r_sample_cnt;
    logic [2:0]          r_corr_en;
    logic                r_locked;
    logic [MW-1:0]       r_miss;
    logic [HW-1:0]       r_hold;
    logic [1:0]          r_nid;
    logic [OUT_DW-1:0]   r_mag;
    logic [TIME_DW-1:0]  r_time;
    logic [TIME_DW-1:0]  r_expected;
    logic                r_found;
    logic [OUT_DW-1:0]   r_found_mag;
    logic [TIME_DW-1:0]  r_found_time;
    logic                r_peak_valid;
    logic [1:0]          r_peak_nid;
    logic [TIME_DW-1:0]  r_peak_time;
    logic [OUT_DW-1:0]   r_peak_mag;

    logic [OUT_DW-1:0]   w_c [4];
    logic [OUT_DW-1:0]   w_c_nid;
    logic                w_s_hit;
    logic [1:0]          w_s_nid;
    logic [OUT_DW-1:0]   w_s_mag;
    logic                w_h_upd;
    logic [OUT_DW-1:0]   w_h_mag;
    logic [TIME_DW-1:0]  w_h_time;
    logic [TIME_DW-1:0]  w_rel;
    logic                w_in_win;
    logic                w_close;
    logic                w_t_hit;
    logic                w_t_found;
    logic [OUT_DW-1:0]   w_t_mag;
    logic [TIME_DW-1:0]  w_t_time;

    // Channel split, search arbitration (largest, then lowest k) and window tests
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            w_c[k] = bus.corr_i[k*OUT_DW +: OUT_DW];
        end
        w_c[3] = '0;
        w_c_nid = w_c[r_nid];

        w_s_hit = 1'b0;
        w_s_nid = '0;
        w_s_mag = '0;
        for (int k = 0; k < 3; k++) begin
            if ((w_c[k] > threshold_i) && (!w_s_hit || (w_c[k] > w_s_mag))) begin
                w_s_hit = 1'b1;
                w_s_nid = 2'(k);
                w_s_mag = w_c[k];
            end
        end

        w_h_upd  = w_c_nid > r_mag;
        w_h_mag  = w_h_upd ? w_c_nid : r_mag;
        w_h_time = w_h_upd ? r_sample_cnt : r_time;

        // Offset from window start; modular arithmetic keeps counter wrap harmless
        w_rel    = r_sample_cnt - (r_expected - TIME_DW'(TRACK_WIN));
        w_in_win = w_rel <= TIME_DW'(2 * TRACK_WIN);
        w_close  = r_sample_cnt == (r_expected + TIME_DW'(TRACK_WIN));

        w_t_hit   = w_in_win && (w_c_nid > threshold_i) && (!r_found || (w_c_nid > r_found_mag));
        w_t_found = r_found || w_t_hit;
        w_t_mag   = w_t_hit ? w_c_nid : r_found_mag;
        w_t_time  = w_t_hit ? r_sample_cnt : r_found_time;
    end

    // Sequencer state, sample counter and registered outputs
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state      <= IDLE;
            r_sample_cnt <= '0;
            r_corr_en    <= '0;
            r_locked     <= 1'b0;
            r_miss       <= '0;
            r_hold       <= '0;
            r_nid        <= '0;
            r_mag        <= '0;
            r_time       <= '0;
            r_expected   <= '0;
            r_found      <= 1'b0;
            r_found_mag  <= '0;
            r_found_time <= '0;
            r_peak_valid <= 1'b0;
            r_peak_nid   <= '0;
            r_peak_time  <= '0;
            r_peak_mag   <= '0;
        end else begin
            r_peak_valid <= 1'b0;
            if (bus.corr_valid_i) begin
                r_sample_cnt <= r_sample_cnt + TIME_DW'(1);
            end
            if (!enable_i) begin
                // Disable overrides any report closing this cycle
                r_state   <= IDLE;
                r_corr_en <= '0;
                r_locked  <= 1'b0;
                r_miss    <= '0;
                r_found   <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state   <= SEARCH;
                        r_corr_en <= 3'b111;
                    end
                    SEARCH: begin
                        if (bus.corr_valid_i && w_s_hit) begin
                            r_nid   <= w_s_nid;
                            r_mag   <= w_s_mag;
                            r_time  <= r_sample_cnt;
                            r_hold  <= '0;
                            r_state <= HOLD;
                        end
                    end
                    HOLD: begin
                        if (bus.corr_valid_i) begin
                            r_hold <= r_hold + HW'(1);
                            r_mag  <= w_h_mag;
                            r_time <= w_h_time;
                            if (r_hold == HW'(HOLD_LEN - 1)) begin
                                r_peak_valid <= 1'b1;
                                r_peak_nid   <= r_nid;
                                r_peak_time  <= w_h_time;
                                r_peak_mag   <= w_h_mag;
                                r_state      <= TRACK;
                                r_corr_en    <= 3'b001 << r_nid;
                                r_locked     <= 1'b1;
                                r_miss       <= '0;
                                r_found      <= 1'b0;
                                r_expected   <= w_h_time + TIME_DW'(PERIOD);
                            end
                        end
                    end
                    TRACK: begin
                        if (bus.corr_valid_i) begin
                            if (w_close) begin
                                r_found <= 1'b0;
                                if (w_t_found) begin
                                    r_peak_valid <= 1'b1;
                                    r_peak_nid   <= r_nid;
                                    r_peak_time  <= w_t_time;
                                    r_peak_mag   <= w_t_mag;
                                    r_expected   <= w_t_time + TIME_DW'(PERIOD);
                                    r_miss       <= '0;
                                end else begin
                                    r_expected <= r_expected + TIME_DW'(PERIOD);
                                    if (r_miss == MW'(MAX_MISS - 1)) begin
                                        r_state   <= SEARCH;
                                        r_locked  <= 1'b0;
                                        r_corr_en <= 3'b111;
                                        r_miss    <= '0;
                                    end else begin
                                        r_miss <= r_miss + MW'(1);
                                    end
                                end
                            end else if (w_in_win) begin
                                r_found      <= w_t_found;
                                r_found_mag  <= w_t_mag;
                                r_found_time <= w_t_time;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign corr_enable_o     = r_corr_en;
    assign locked_o          = r_locked;
    assign miss_cnt_o        = r_miss;
    assign state_o           = 2'(r_state);
    assign bus.peak_valid_o  = r_peak_valid;
    assign bus.peak_n_id_2_o = r_peak_nid;
    assign bus.peak_time_o   = r_peak_time;
    assign bus.peak_mag_o    = r_peak_mag;
endmodule

// File: tb/tb_pss_search_ctrl.sv
// Directed bench for pss_search_ctrl: reset, search, tie, track, miss, enable drop.
module tb_pss_search_ctrl;
    logic        clk_i = 1'b0;
    logic        reset_ni = 1'b0;
    logic        enable_i = 1'b0;
    logic [23:0] threshold_i = 24'd100;
    logic [2:0]  corr_en;
    logic        locked;
    logic [1:0]  miss;
    logic [1:0]  state;

    int total = 0;
    int bad = 0;
    int pulses = 0;
    int idx = 0;

    pss_search_ctrl_if #(.OUT_DW(24), .TIME_DW(32)) bus ();

    pss_search_ctrl #(
        .OUT_DW(24), .PERIOD(64), .HOLD_LEN(4), .TRACK_WIN(2), .MAX_MISS(3), .TIME_DW(32)
    ) dut (
        .clk_i(clk_i), .reset_ni(reset_ni), .enable_i(enable_i), .threshold_i(threshold_i),
        .bus(bus), .corr_enable_o(corr_en), .locked_o(locked), .miss_cnt_o(miss), .state_o(state)
    );

    always #5 clk_i = ~clk_i;

    // Count report pulses on the falling edge, away from the update edge
    always @(negedge clk_i) if (bus.peak_valid_o === 1'b1) pulses++;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic send_beat(input int c0, input int c1, input int c2);
        bus.corr_i       = {24'(c2), 24'(c1), 24'(c0)};
        bus.corr_valid_i = 1'b1;
        @(posedge clk_i); #1;
        bus.corr_valid_i = 1'b0;
        idx++;
    endtask

    task automatic send_bg_to(input int last);
        while (idx <= last) send_beat(10, 10, 10);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset;
        #1;
        total++; if (state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
        total++; if (corr_en !== 3'b000) begin bad++; $display("FAIL reset_corr_en got=%b exp=000", corr_en); end
        total++; if ({locked, miss, bus.peak_valid_o} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {locked, miss, bus.peak_valid_o}); end
        total++; if ({bus.peak_n_id_2_o, bus.peak_time_o, bus.peak_mag_o} !== 58'd0) begin bad++; $display("FAIL reset_peak got=%h exp=0", {bus.peak_n_id_2_o, bus.peak_time_o, bus.peak_mag_o}); end
        // Enter HOLD, then reset mid-hold for two cycles
        reset_ni = 1'b1; enable_i = 1'b1;
        idle(1);
        send_beat(150, 10, 10);
        total++; if (state !== 2'd2) begin bad++; $display("FAIL pre_reset_hold got=%0d exp=2", state); end
        send_beat(10, 10, 10);
        reset_ni = 1'b0;
        idle(2);
        total++; if ({state, corr_en, locked, miss} !== 8'd0) begin bad++; $display("FAIL midhold_reset got=%b exp=0", {state, corr_en, locked, miss}); end
        reset_ni = 1'b1;
        idx = 0;
        idle(1);
        total++; if (state !== 2'd1) begin bad++; $display("FAIL release_state got=%0d exp=1", state); end
        total++; if (corr_en !== 3'b111) begin bad++; $display("FAIL release_corr_en got=%b exp=111", corr_en); end
    endtask

    task automatic test_search;
        send_bg_to(9);
        total++; if (state !== 2'd1) begin bad++; $display("FAIL search_bg_state got=%0d exp=1", state); end
        send_beat(10, 150, 10);                 // beat 10 trigger
        total++; if (state !== 2'd2) begin bad++; $display("FAIL search_trigger got=%0d exp=2", state); end
        send_beat(10, 10, 10);                  // 11
        send_beat(10, 200, 10);                 // 12
        send_beat(300, 10, 10);                 // 13, other channel
        total++; if (bus.peak_valid_o !== 1'b0) begin bad++; $display("FAIL search_early_pulse got=%b exp=0", bus.peak_valid_o); end
        send_beat(10, 10, 10);                  // 14 closes hold
        total++; if (bus.peak_valid_o !== 1'b1) begin bad++; $display("FAIL search_pulse got=%b exp=1", bus.peak_valid_o); end
        total++; if (bus.peak_n_id_2_o !== 2'd1) begin bad++; $display("FAIL search_nid got=%0d exp=1", bus.peak_n_id_2_o); end
        total++; if (bus.peak_time_o !== 32'd12) begin bad++; $display("FAIL search_time got=%0d exp=12", bus.peak_time_o); end
        total++; if (bus.peak_mag_o !== 24'd200) begin bad++; $display("FAIL search_mag got=%0d exp=200", bus.peak_mag_o); end
        total++; if ({corr_en, locked, state} !== {3'b010, 1'b1, 2'd3}) begin bad++; $display("FAIL search_lock got=%b exp=010111", {corr_en, locked, state}); end
        idle(1);
        total++; if (bus.peak_valid_o !== 1'b0 || bus.peak_time_o !== 32'd12) begin bad++; $display("FAIL search_pulse_end got=%b/%0d exp=0/12", bus.peak_valid_o, bus.peak_time_o); end
        total++; if (pulses !== 1) begin bad++; $display("FAIL search_pulse_count got=%0d exp=1", pulses); end
    endtask

    task automatic test_track;
        send_bg_to(72);
        send_beat(10, 999, 10);                 // 73, just before window
        send_bg_to(76);
        send_beat(500, 180, 10);                // 77
        total++; if (bus.peak_valid_o !== 1'b0 || state !== 2'd3) begin bad++; $display("FAIL track_open got=%b/%0d exp=0/3", bus.peak_valid_o, state); end
        send_beat(10, 10, 10);                  // 78 closes window
        total++; if (bus.peak_valid_o !== 1'b1) begin bad++; $display("FAIL track_pulse got=%b exp=1", bus.peak_valid_o); end
        total++; if (bus.peak_time_o !== 32'd77) begin bad++; $display("FAIL track_time got=%0d exp=77", bus.peak_time_o); end
        total++; if (bus.peak_mag_o !== 24'd180 || bus.peak_n_id_2_o !== 2'd1) begin bad++; $display("FAIL track_mag got=%0d/%0d exp=180/1", bus.peak_mag_o, bus.peak_n_id_2_o); end
        total++; if (miss !== 2'd0) begin bad++; $display("FAIL track_miss got=%0d exp=0", miss); end
    endtask

    task automatic test_miss;
        send_bg_to(137);
        send_beat(10, 150, 10);                 // 138, outside window 139..143
        send_bg_to(140);
        send_beat(200, 10, 10);                 // 141, unlocked channel
        send_bg_to(142);
        total++; if (miss !== 2'd0) begin bad++; $display("FAIL miss_before_close got=%0d exp=0", miss); end
        send_beat(10, 10, 10);                  // 143
        total++; if (miss !== 2'd1 || state !== 2'd3) begin bad++; $display("FAIL miss_one got=%0d/%0d exp=1/3", miss, state); end
        send_bg_to(204);
        send_beat(10, 100, 10);                 // 205, equals threshold
        send_bg_to(206);
        total++; if (miss !== 2'd1) begin bad++; $display("FAIL miss_mid_window got=%0d exp=1", miss); end
        send_bg_to(207);
        total++; if (miss !== 2'd2) begin bad++; $display("FAIL miss_two got=%0d exp=2", miss); end
        send_bg_to(271);
        total++; if (state !== 2'd1 || locked !== 1'b0) begin bad++; $display("FAIL miss_fallback got=%0d/%b exp=1/0", state, locked); end
        total++; if (corr_en !== 3'b111 || miss !== 2'd0) begin bad++; $display("FAIL miss_reenable got=%b/%0d exp=111/0", corr_en, miss); end
        total++; if (pulses !== 2) begin bad++; $display("FAIL miss_pulse_count got=%0d exp=2", pulses); end
    endtask

    task automatic test_tie;
        send_beat(10, 100, 10);                 // 272, equals threshold
        total++; if (state !== 2'd1) begin bad++; $display("FAIL tie_equal_thr got=%0d exp=1", state); end
        send_beat(150, 10, 150);                // 273
        total++; if (state !== 2'd2) begin bad++; $display("FAIL tie_trigger got=%0d exp=2", state); end
        send_beat(10, 10, 10);                  // 274
        send_beat(150, 10, 10);                 // 275, equal mag does not update
        send_beat(10, 10, 10);                  // 276
        send_beat(10, 10, 10);                  // 277 closes hold
        total++; if (bus.peak_valid_o !== 1'b1 || bus.peak_n_id_2_o !== 2'd0) begin bad++; $display("FAIL tie_nid got=%b/%0d exp=1/0", bus.peak_valid_o, bus.peak_n_id_2_o); end
        total++; if (bus.peak_time_o !== 32'd273 || bus.peak_mag_o !== 24'd150) begin bad++; $display("FAIL tie_time got=%0d/%0d exp=273/150", bus.peak_time_o, bus.peak_mag_o); end
        total++; if (corr_en !== 3'b001) begin bad++; $display("FAIL tie_corr_en got=%b exp=001", corr_en); end
    endtask

    task automatic test_enable_drop;
        enable_i = 1'b0;
        idle(1);
        total++; if ({state, corr_en, locked} !== 6'd0) begin bad++; $display("FAIL disable_idle got=%b exp=0", {state, corr_en, locked}); end
        enable_i = 1'b1;
        idle(1);
        total++; if (state !== 2'd1) begin bad++; $display("FAIL reenable got=%0d exp=1", state); end
        send_beat(10, 10, 160);                 // trigger
        send_beat(10, 10, 10);
        send_beat(10, 10, 10);
        send_beat(10, 10, 10);
        enable_i = 1'b0;
        send_beat(10, 10, 10);                  // hold-closing beat with enable low
        total++; if (state !== 2'd0 || bus.peak_valid_o !== 1'b0) begin bad++; $display("FAIL drop_close got=%0d/%b exp=0/0", state, bus.peak_valid_o); end
        total++; if (corr_en !== 3'b000 || locked !== 1'b0) begin bad++; $display("FAIL drop_outputs got=%b/%b exp=000/0", corr_en, locked); end
        idle(1);
        total++; if (pulses !== 3 || bus.peak_time_o !== 32'd273) begin bad++; $display("FAIL drop_no_pulse got=%0d/%0d exp=3/273", pulses, bus.peak_time_o); end
    endtask

    initial begin
        bus.corr_i       = '0;
        bus.corr_valid_i = 1'b0;
        test_reset();
        test_search();
        test_track();
        test_miss();
        test_tie();
        test_enable_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
